lizwiz_input_ctrl: RTL and testbench
====================================

// Module: lizwiz_input_ctrl
// PURPOSE
//  Player-input front end feeding the pacman core's in0_reg/in1_reg ports. Decodes the hps_io ps2_key
//  toggle stream, merges joystick words, applies Horz-orientation remap, generates timed coin pulses
//  on start/coin presses, and drives registered active-low input bytes.
// PARAMETERS
//  COIN_PULSE_CYC  2_400_000  clk_sys cycles the coin bit is held active (100 ms @ 24 MHz)
//  COIN_GAP_CYC    2_400_000  min inactive cycles after a coin pulse before the next one
//  CNT_W           22         coin counter width; must hold max(COIN_PULSE_CYC, COIN_GAP_CYC)-1
// PORTS
//  clk_sys    in   1   system clock (24 MHz)
//  reset_n    in   1   asynchronous, active-low reset
//  ps2_key    in   11  [10] toggle per event, [9] pressed, [8:0] scancode ({ext,code})
//  joy0       in   16  P1 joystick: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//  joy1       in   16  P2 joystick, same bit map
//  rotate     in   1   1 = Horz orientation (status[2]), remap directions
//  in0_reg    out  8   ~{coin2,1'b0,coin1,test,down,right,left,up}
//  in1_reg    out  8   ~{fire2,start2,start1,fire,down2,right2,left2,up2}
//  coin_busy  out  1   coin FSM not IDLE (LED/debug)
// BEHAVIOUR
//  Reset (async, reset_n=0): all key regs 0, armed=0, FSM IDLE, counter 0, pending=0,
//   in0_reg=8'hFF, in1_reg=8'hFF, coin_busy=0.
//  PS/2: reg old_tog, armed. First cycle after reset: old_tog<=ps2_key[10], armed<=1, no decode.
//   Thereafter decode only when ps2_key[10]!=old_tog; key reg <= ps2_key[9]. Table (hex):
//   X75 up, X72 down, X6B left, X74 right (ext bit ignored); 029 space, 014 ctrl (separate regs,
//   fire = space|ctrl); 005/016 start1; 006/01E start2; 02E coin1; 036 coin2; 02D up2, 02B down2,
//   023 left2, 034 right2, 01C fire2, 02C test. Unlisted codes ignored.
//  Merge: dirs = key|joy per player. rotate=1: up<=left, down<=right, left<=down, right<=up
//   (same for P2); rotate=0 identity. start1 = keys|joy0[5]|joy1[5]; start2 likewise with [6].
//  Coin FSM (sub-module): request = rising edge of (start1|start2|coin1key), sampled by a 1-cycle
//   delay reg. IDLE: request -> PULSE, cnt<=COIN_PULSE_CYC-1, coin1=1. PULSE: cnt!=0 dec;
//   cnt==0 -> GAP, cnt<=COIN_GAP_CYC-1, coin1=0. GAP: cnt!=0 dec; cnt==0 -> (pending ? PULSE,
//   clear pending, reload : IDLE). Request in PULSE/GAP sets pending (depth 1; extras dropped).
//   Request in same cycle as GAP exit is served by that transition (no double count).
//  coin2 = coin2 key level, not timed. Bit6 of in0 constant 0 before inversion.
//  Outputs registered: 1 clk_sys latency from key reg/joy/FSM state to in0_reg/in1_reg.
//   Keyboard event to output: 2 cycles. Coin pulse is exactly COIN_PULSE_CYC cycles low on in0[5].
//  Reset mid-pulse: pulse aborts immediately (in0_reg=8'hFF), pending cleared.
// STRUCTURE
//  Package lizwiz_input_pkg: scancode localparams, in0/in1 bit-index localparams, coin FSM
//   enum {IDLE,PULSE,GAP}.
//  Sub-module lizwiz_coin_pulse (FSM + counter + pending); top holds decode, remap, output regs.
// TESTING (use COIN_PULSE_CYC=8, COIN_GAP_CYC=4, CNT_W=4)
//  Reset: hold reset_n=0 with keys/joy active -> in0_reg=FF, in1_reg=FF, coin_busy=0.
//  Toggle ps2_key to {1,1,029} then {0,1,014}; release {1,0,029} -> in1[4]=0 2 clk after first
//   event, stays 0 while ctrl held; 1 after ctrl release {0,0,014}.
//  rotate=1, joy0=16'h0002 (L) -> in0[3:0]=4'b1110 (up); rotate=0 -> in0[3:0]=4'b1101 (left).
//  joy0[5] pulse 1 clk -> in0[5]=0 for exactly 8 clks, in1[5] low only 1 clk; coin_busy 12 clks.
//  Two start presses 3 clks apart -> two 8-clk coin pulses separated by 4-clk gap; third press
//   during first pulse dropped (still two pulses).
//  Drop reset_n at pulse clk 3 -> in0_reg=FF same cycle; after release no residual pulse.

Source files
------------

// File: rtl/lizwiz_input_pkg.sv
// Shared scancodes, input-byte bit positions, coin FSM states and key-state payload
// for the lizwiz player-input front end.
package lizwiz_input_pkg;

    // Direction keys match on the low 8 bits so extended and plain codes both work
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [8:0] SC_SPACE   = 9'h029;
    localparam logic [8:0] SC_CTRL    = 9'h014;
    localparam logic [8:0] SC_START1A = 9'h005;
    localparam logic [8:0] SC_START1B = 9'h016;
    localparam logic [8:0] SC_START2A = 9'h006;
    localparam logic [8:0] SC_START2B = 9'h01E;
    localparam logic [8:0] SC_COIN1   = 9'h02E;
    localparam logic [8:0] SC_COIN2   = 9'h036;
    localparam logic [8:0] SC_UP2     = 9'h02D;
    localparam logic [8:0] SC_DOWN2   = 9'h02B;
    localparam logic [8:0] SC_LEFT2   = 9'h023;
    localparam logic [8:0] SC_RIGHT2  = 9'h034;
    localparam logic [8:0] SC_FIRE2   = 9'h01C;
    localparam logic [8:0] SC_TEST    = 9'h02C;

    localparam int unsigned IN0_UP    = 0;
    localparam int unsigned IN0_LEFT  = 1;
    localparam int unsigned IN0_RIGHT = 2;
    localparam int unsigned IN0_DOWN  = 3;
    localparam int unsigned IN0_TEST  = 4;
    localparam int unsigned IN0_COIN1 = 5;
    localparam int unsigned IN0_COIN2 = 7;

    localparam int unsigned IN1_UP2    = 0;
    localparam int unsigned IN1_LEFT2  = 1;
    localparam int unsigned IN1_RIGHT2 = 2;
    localparam int unsigned IN1_DOWN2  = 3;
    localparam int unsigned IN1_FIRE   = 4;
    localparam int unsigned IN1_START1 = 5;
    localparam int unsigned IN1_START2 = 6;
    localparam int unsigned IN1_FIRE2  = 7;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic space;
        logic ctrl;
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
        logic up2;
        logic down2;
        logic left2;
        logic right2;
        logic fire2;
        logic test;
    } key_state_t;

endpackage

// File: rtl/lizwiz_coin_pulse.sv
// Coin pulse generator: rising edge of the trigger starts a fixed-length pulse followed by
// a mandatory gap; one request arriving while busy is remembered and served after the gap.
module lizwiz_coin_pulse
    import lizwiz_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 2_400_000,
    parameter int unsigned COIN_GAP_CYC   = 2_400_000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic coin_c,
    output logic busy_c
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);

    coin_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             trig_q;
    logic             req_c;

    assign req_c = trig & ~trig_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            trig_q    <= trig;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (req_c) pending_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (req_c) pending_d = 1'b1;
                end else if (pending_q || req_c) begin
                    // A request landing on the exit cycle is absorbed by this reload
                    state_d   = PULSE;
                    cnt_d     = PULSE_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign coin_c = (state_q == PULSE);
    assign busy_c = (state_q != IDLE);

endmodule

// File: rtl/lizwiz_input_ctrl.sv
// Player-input front end: PS/2 toggle-stream decode, joystick merge, orientation remap,
// coin pulse generation and registered active-low input bytes for the core.
module lizwiz_input_ctrl
    import lizwiz_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 2_400_000,
    parameter int unsigned COIN_GAP_CYC   = 2_400_000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        rotate,
    output logic [7:0]  in0_reg,
    output logic [7:0]  in1_reg,
    output logic        coin_busy
);

    key_state_t key_q;
    logic       old_tog_q, armed_q;
    logic [8:0] code;
    logic       pressed;

    logic up_m, down_m, left_m, right_m;
    logic up2_m, down2_m, left2_m, right2_m;
    logic start1_m, start2_m;
    logic coin1_c, busy_c;
    logic [7:0] in0_n, in1_n;
    logic unused_joy;

    assign code    = ps2_key[8:0];
    assign pressed = ps2_key[9];
    assign unused_joy = ^{joy0[15:7], joy1[15:7]};

    // First cycle out of reset only learns the toggle phase, so a stale event is never decoded
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q     <= '0;
            old_tog_q <= 1'b0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            old_tog_q <= ps2_key[10];
            armed_q   <= 1'b1;
        end else if (ps2_key[10] != old_tog_q) begin
            old_tog_q <= ps2_key[10];
            if (code[7:0] == SC_UP)    key_q.up    <= pressed;
            if (code[7:0] == SC_DOWN)  key_q.down  <= pressed;
            if (code[7:0] == SC_LEFT)  key_q.left  <= pressed;
            if (code[7:0] == SC_RIGHT) key_q.right <= pressed;
            case (code)
                SC_SPACE:               key_q.space  <= pressed;
                SC_CTRL:                key_q.ctrl   <= pressed;
                SC_START1A, SC_START1B: key_q.start1 <= pressed;
                SC_START2A, SC_START2B: key_q.start2 <= pressed;
                SC_COIN1:               key_q.coin1  <= pressed;
                SC_COIN2:               key_q.coin2  <= pressed;
                SC_UP2:                 key_q.up2    <= pressed;
                SC_DOWN2:               key_q.down2  <= pressed;
                SC_LEFT2:               key_q.left2  <= pressed;
                SC_RIGHT2:              key_q.right2 <= pressed;
                SC_FIRE2:               key_q.fire2  <= pressed;
                SC_TEST:                key_q.test   <= pressed;
                default: ;
            endcase
        end
    end

    assign start1_m = key_q.start1 | joy0[5] | joy1[5];
    assign start2_m = key_q.start2 | joy0[6] | joy1[6];

    lizwiz_coin_pulse #(
        .COIN_PULSE_CYC (COIN_PULSE_CYC),
        .COIN_GAP_CYC   (COIN_GAP_CYC),
        .CNT_W          (CNT_W)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .trig    (start1_m | start2_m | key_q.coin1),
        .coin_c  (coin1_c),
        .busy_c  (busy_c)
    );

    // Merge keyboard with joysticks; Horz orientation rotates the direction set
    always_comb begin
        up_m     = key_q.up     | joy0[3];
        down_m   = key_q.down   | joy0[2];
        left_m   = key_q.left   | joy0[1];
        right_m  = key_q.right  | joy0[0];
        up2_m    = key_q.up2    | joy1[3];
        down2_m  = key_q.down2  | joy1[2];
        left2_m  = key_q.left2  | joy1[1];
        right2_m = key_q.right2 | joy1[0];
        in0_n = '0;
        in1_n = '0;
        in0_n[IN0_UP]     = rotate ? left_m  : up_m;
        in0_n[IN0_DOWN]   = rotate ? right_m : down_m;
        in0_n[IN0_LEFT]   = rotate ? down_m  : left_m;
        in0_n[IN0_RIGHT]  = rotate ? up_m    : right_m;
        in0_n[IN0_TEST]   = key_q.test;
        in0_n[IN0_COIN1]  = coin1_c;
        in0_n[IN0_COIN2]  = key_q.coin2;
        in1_n[IN1_UP2]    = rotate ? left2_m  : up2_m;
        in1_n[IN1_DOWN2]  = rotate ? right2_m : down2_m;
        in1_n[IN1_LEFT2]  = rotate ? down2_m  : left2_m;
        in1_n[IN1_RIGHT2] = rotate ? up2_m    : right2_m;
        in1_n[IN1_FIRE]   = key_q.space | key_q.ctrl | joy0[4];
        in1_n[IN1_START1] = start1_m;
        in1_n[IN1_START2] = start2_m;
        in1_n[IN1_FIRE2]  = key_q.fire2 | joy1[4];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in0_reg   <= 8'hFF;
            in1_reg   <= 8'hFF;
            coin_busy <= 1'b0;
        end else begin
            in0_reg   <= ~in0_n;
            in1_reg   <= ~in1_n;
            coin_busy <= busy_c;
        end
    end

endmodule

// File: tb/tb_lizwiz_input_ctrl.sv
// Directed bench for lizwiz_input_ctrl with short coin timing (pulse 8, gap 4).
module tb_lizwiz_input_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joy0;
    logic [15:0] joy1;
    logic        rotate;
    logic [7:0]  in0_reg;
    logic [7:0]  in1_reg;
    logic        coin_busy;

    int   checks;
    int   errors;
    logic tog;

    lizwiz_input_ctrl #(
        .COIN_PULSE_CYC (8),
        .COIN_GAP_CYC   (4),
        .CNT_W          (4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joy0      (joy0),
        .joy1      (joy1),
        .rotate    (rotate),
        .in0_reg   (in0_reg),
        .in1_reg   (in1_reg),
        .coin_busy (coin_busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic prs, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, prs, code};
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        joy0 = 16'h007F;
        joy1 = 16'h007F;
        rotate = 1'b0;
        ps2_key = 11'h7FF;
        step(2);
        checks++;
        if (in0_reg !== 8'hFF) begin errors++; $display("FAIL reset_in0: got %h expected ff", in0_reg); end
        checks++;
        if (in1_reg !== 8'hFF) begin errors++; $display("FAIL reset_in1: got %h expected ff", in1_reg); end
        checks++;
        if (coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", coin_busy); end
        joy0 = '0;
        joy1 = '0;
        ps2_key = '0;
        tog = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(3);
        checks++;
        if (in0_reg !== 8'hFF || in1_reg !== 8'hFF) begin
            errors++;
            $display("FAIL idle_after_reset: got %h/%h expected ff/ff", in0_reg, in1_reg);
        end
    endtask

    task automatic test_fire_keys;
        send_key(1'b1, 9'h029);
        step(1);
        checks++;
        if (in1_reg !== 8'hFF) begin errors++; $display("FAIL fire_latency1: got %h expected ff", in1_reg); end
        step(1);
        checks++;
        if (in1_reg !== 8'hEF) begin errors++; $display("FAIL fire_space: got %h expected ef", in1_reg); end
        send_key(1'b1, 9'h014);
        step(2);
        checks++;
        if (in1_reg !== 8'hEF) begin errors++; $display("FAIL fire_both: got %h expected ef", in1_reg); end
        send_key(1'b0, 9'h029);
        step(2);
        checks++;
        if (in1_reg !== 8'hEF) begin errors++; $display("FAIL fire_ctrl_held: got %h expected ef", in1_reg); end
        send_key(1'b0, 9'h014);
        step(1);
        checks++;
        if (in1_reg !== 8'hEF) begin errors++; $display("FAIL fire_rel_latency: got %h expected ef", in1_reg); end
        step(1);
        checks++;
        if (in1_reg !== 8'hFF) begin errors++; $display("FAIL fire_released: got %h expected ff", in1_reg); end
    endtask

    task automatic test_keyboard_map;
        logic [8:0] codes [9] = '{9'h175, 9'h072, 9'h16B, 9'h074, 9'h02C, 9'h036, 9'h02D, 9'h01C, 9'h01A};
        logic [7:0] exp0 [9]  = '{8'hFE,  8'hF7,  8'hFD,  8'hFB,  8'hEF,  8'h7F,  8'hFF,  8'hFF,  8'hFF};
        logic [7:0] exp1 [9]  = '{8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFE,  8'h7F,  8'hFF};
        for (int i = 0; i < 9; i++) begin
            send_key(1'b1, codes[i]);
            step(2);
            checks++;
            if (in0_reg !== exp0[i] || in1_reg !== exp1[i]) begin
                errors++;
                $display("FAIL keymap_press code=%h: got %h/%h expected %h/%h", codes[i], in0_reg, in1_reg, exp0[i], exp1[i]);
            end
            send_key(1'b0, codes[i]);
            step(2);
            checks++;
            if (in0_reg !== 8'hFF || in1_reg !== 8'hFF) begin
                errors++;
                $display("FAIL keymap_release code=%h: got %h/%h expected ff/ff", codes[i], in0_reg, in1_reg);
            end
        end
    endtask

    task automatic test_rotate;
        rotate = 1'b1;
        joy0 = 16'h0002;
        step(2);
        checks++;
        if (in0_reg !== 8'hFE) begin errors++; $display("FAIL rot_left_to_up: got %h expected fe", in0_reg); end
        rotate = 1'b0;
        step(2);
        checks++;
        if (in0_reg !== 8'hFD) begin errors++; $display("FAIL norot_left: got %h expected fd", in0_reg); end
        rotate = 1'b1;
        joy0 = 16'h0008;
        step(2);
        checks++;
        if (in0_reg !== 8'hFB) begin errors++; $display("FAIL rot_up_to_right: got %h expected fb", in0_reg); end
        joy0 = 16'h0000;
        joy1 = 16'h0001;
        step(2);
        checks++;
        if (in1_reg !== 8'hF7) begin errors++; $display("FAIL rot_p2_right_to_down: got %h expected f7", in1_reg); end
        joy1 = 16'h0000;
        rotate = 1'b0;
        step(2);
        checks++;
        if (in0_reg !== 8'hFF || in1_reg !== 8'hFF) begin
            errors++;
            $display("FAIL rot_cleared: got %h/%h expected ff/ff", in0_reg, in1_reg);
        end
    endtask

    task automatic test_coin_pulse;
        logic exp_coin;
        logic exp_busy;
        joy0 = 16'h0020;
        step(1);
        joy0 = 16'h0000;
        checks++;
        if (in1_reg !== 8'hDF || in0_reg !== 8'hFF || coin_busy !== 1'b0) begin
            errors++;
            $display("FAIL coin_start_edge: got %h/%h/%b expected df/ff/0", in1_reg, in0_reg, coin_busy);
        end
        for (int c = 1; c <= 16; c++) begin
            step(1);
            exp_coin = (c <= 8) ? 1'b0 : 1'b1;
            exp_busy = (c <= 12);
            checks++;
            if (in0_reg[5] !== exp_coin || coin_busy !== exp_busy) begin
                errors++;
                $display("FAIL coin_pulse c=%0d: got coin_n=%b busy=%b expected %b/%b", c, in0_reg[5], coin_busy, exp_coin, exp_busy);
            end
            if (c == 1) begin
                checks++;
                if (in1_reg !== 8'hFF) begin errors++; $display("FAIL start_one_clk: got %h expected ff", in1_reg); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_coin;
        logic exp_busy;
        logic exp_start;
        for (int c = 0; c < 30; c++) begin
            joy0 = (c == 0 || c == 3 || c == 5) ? 16'h0020 : 16'h0000;
            step(1);
            exp_coin  = ((c >= 1 && c <= 8) || (c >= 13 && c <= 20)) ? 1'b0 : 1'b1;
            exp_busy  = (c >= 1 && c <= 24);
            exp_start = (c == 0 || c == 3 || c == 5) ? 1'b0 : 1'b1;
            checks++;
            if (in0_reg[5] !== exp_coin || coin_busy !== exp_busy || in1_reg[5] !== exp_start) begin
                errors++;
                $display("FAIL back_to_back c=%0d: got coin_n=%b busy=%b start_n=%b expected %b/%b/%b",
                         c, in0_reg[5], coin_busy, in1_reg[5], exp_coin, exp_busy, exp_start);
            end
        end
        joy0 = 16'h0000;
    endtask

    task automatic test_reset_mid_pulse;
        joy0 = 16'h0020;
        step(1);
        joy0 = 16'h0000;
        step(3);
        checks++;
        if (in0_reg !== 8'hDF) begin errors++; $display("FAIL mid_pulse_active: got %h expected df", in0_reg); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (in0_reg !== 8'hFF || coin_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_abort: got %h/%b expected ff/0", in0_reg, coin_busy);
        end
        step(2);
        reset_n = 1'b1;
        step(1);
        for (int i = 0; i < 15; i++) begin
            step(1);
            checks++;
            if (in0_reg !== 8'hFF || coin_busy !== 1'b0) begin
                errors++;
                $display("FAIL no_residual_pulse i=%0d: got %h/%b expected ff/0", i, in0_reg, coin_busy);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tog = 1'b0;
        test_reset;
        test_fire_keys;
        test_keyboard_map;
        test_rotate;
        test_coin_pulse;
        test_back_to_back;
        test_reset_mid_pulse;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
